// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 definitions for ps2_rx and ps2_tx: receiver state
//               encoding, frame geometry, command/response codes and a
//               parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    // Receiver states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_rx_state_t;

    // Frame geometry: start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    // Command / response codes seen on the bus
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    // True when data plus parity bit carry an odd number of ones
    function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS:0] word);
        return ^word;
    endfunction

endpackage : ps2_pkg

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ============================================================================
// Module      : ps2_line_filter
// Description : Two-flop synchroniser, FILTER_LEN-sample level filter and
//               single-cycle falling-edge pulse for one PS/2 line. Presets to
//               the idle-high bus level on reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_fall
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;
    logic                  r_fall;

    // Synchronise, keep the last FILTER_LEN samples, and only move the level
    // when the whole window agrees; the edge pulse fires as the level drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
            if (&r_hist) begin
                r_level <= 1'b1;
            end else if (~|r_hist) begin
                r_level <= 1'b0;
            end
            r_fall <= r_level & ~|r_hist;
        end
    end

    assign o_fall = r_fall;

endmodule : ps2_line_filter

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host receiver. Samples data on filtered PS/2
//               clock falling edges, checks start/parity/stop framing and
//               emits one byte per good frame, with error pulses otherwise.
//               Optional macro PS2_RX_PARITY_CHECK_EN enables odd-parity
//               checking; without it the parity bit is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     ps2c_i,
    input  logic                     ps2d_i,
    input  logic                     rx_en_i,
    output logic [PS2_DATA_BITS-1:0] rx_data_o,
    output logic                     rx_done_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     idle_o
);

    localparam int                   c_SHIFT_W   = PS2_FRAME_BITS - 1;
    localparam int                   c_TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]           c_START_CNT = 4'(PS2_FRAME_BITS - 1);

    ps2_rx_state_t           r_state, w_state_nxt;
    logic [3:0]              r_bit_cnt, w_bit_cnt_nxt;
    logic [c_SHIFT_W-1:0]    r_shift, w_shift_nxt;
    logic [c_TIMER_W-1:0]    r_timer, w_timer_nxt;
    logic [PS2_DATA_BITS-1:0] r_data, w_data_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_perr, w_perr_nxt;
    logic                    r_ferr, w_ferr_nxt;
    logic [1:0]              r_ps2d_sync;
    logic                    w_fall;
    logic                    w_ps2d;
    logic [c_SHIFT_W-1:0]    w_frame;
    logic                    w_parity_ok;
    logic                    w_unused;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_ps2c_filter (
        .clk    (clk_i),
        .rst_n  (reset_ni),
        .i_line (ps2c_i),
        .o_fall (w_fall)
    );

    // Data is stable for half a PS/2 period around each fall, so a plain
    // two-flop synchroniser is enough here
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ps2d_sync <= 2'b11;
        end else begin
            r_ps2d_sync <= {r_ps2d_sync[0], ps2d_i};
        end
    end

    assign w_ps2d = r_ps2d_sync[1];

    // Shift register contents once the current bit is taken in; on the stop
    // fall this is {stop, parity, D7..D0}
    assign w_frame = {w_ps2d, r_shift[c_SHIFT_W-1:1]};

`ifdef PS2_RX_PARITY_CHECK_EN
    assign w_parity_ok  = ps2_odd_parity_ok(w_frame[PS2_DATA_BITS:0]);
    assign parity_err_o = r_perr;
    assign w_unused     = &{1'b0, r_shift[0]};
`else
    assign w_parity_ok  = 1'b1;
    assign parity_err_o = 1'b0;
    assign w_unused     = &{1'b0, r_shift[0], w_frame[PS2_DATA_BITS], r_perr};
`endif

    // Next-state and frame verdict; the verdict is taken on the stop-bit
    // fall so the pulses are visible during the single CHECK cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_timer_nxt   = r_timer;
        w_data_nxt    = r_data;
        w_done_nxt    = 1'b0;
        w_perr_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall && rx_en_i && !w_ps2d) begin
                    w_state_nxt   = RECV;
                    w_bit_cnt_nxt = c_START_CNT;
                    w_timer_nxt   = '0;
                end
            end
            RECV: begin
                if (!rx_en_i) begin
                    w_state_nxt = IDLE;
                end else if (w_fall) begin
                    // A fall beats a coincident timeout
                    w_shift_nxt   = w_frame;
                    w_bit_cnt_nxt = r_bit_cnt - 4'd1;
                    w_timer_nxt   = '0;
                    if (r_bit_cnt == 4'd1) begin
                        w_state_nxt = CHECK;
                        if (!w_frame[c_SHIFT_W-1]) begin
                            w_ferr_nxt = 1'b1;
                        end else if (!w_parity_ok) begin
                            w_perr_nxt = 1'b1;
                        end else begin
                            w_data_nxt = w_frame[PS2_DATA_BITS-1:0];
                            w_done_nxt = 1'b1;
                        end
                    end
                end else if (r_timer == c_TIMER_MAX) begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer + c_TIMER_W'(1);
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and output pulse registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_timer   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_timer   <= w_timer_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_perr    <= w_perr_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    assign rx_data_o   = r_data;
    assign rx_done_o   = r_done;
    assign frame_err_o = r_ferr;
    assign idle_o      = (r_state == IDLE);

endmodule : ps2_rx

`default_nettype wire

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host receiver; sibling stage to ps2_tx on the same PS/2 clock/data pair.
- Consumes device frames (keyboard scan codes, mouse ACK 0xFA, movement packets) and hands bytes downstream to the input decoder that drives the sand-game cursor and controls.
- Synchronises and deglitches the PS/2 clock, samples data on filtered falling edges, checks the frame, and emits one byte per valid frame.
- Upstream arbiter deasserts rx_en_i while ps2_tx owns the bus.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised ps2c samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 200_000: maximum clk_i cycles between filtered falling edges inside a frame (2 ms at 100 MHz).

Ports:
- clk_i  input  1  system clock, 100 MHz.
- reset_ni  input  1  asynchronous, active-low reset.
- ps2c_i  input  1  raw PS/2 clock line, asynchronous.
- ps2d_i  input  1  raw PS/2 data line, asynchronous.
- rx_en_i  input  1  receive enable; low aborts and blocks reception.
- rx_data_o  output  8  last good byte; updated only with rx_done_o.
- rx_done_o  output  1  one-cycle pulse: rx_data_o newly valid.
- parity_err_o  output  1  one-cycle pulse: odd-parity failure.
- frame_err_o  output  1  one-cycle pulse: bad stop bit or inter-edge timeout.
- idle_o  output  1  high in IDLE.

Behaviour:
- Reset (async, reset_ni=0):
  - state=IDLE; rx_data_o=0x00; rx_done_o, parity_err_o, frame_err_o = 0; idle_o=1.
  - Synchronisers and filter preset to 1 (bus idle-high).
- Input conditioning:
  - ps2c_i and ps2d_i each pass through a 2-FF synchroniser.
  - Filtered clock goes to 1 when the last FILTER_LEN synchronised ps2c samples are all 1, goes to 0 when they are all 0, and otherwise holds.
  - fall = filtered clock 1->0; asserted for exactly one cycle.
- Frame format: start bit 0, D0..D7 LSB first, odd parity, stop bit 1 (11 bits).
- States:
  - IDLE: on fall with rx_en_i=1 and synchronised data=0 -> RECV; bit counter=10, timer cleared. On fall with data=1, or with rx_en_i=0, stay in IDLE.
  - RECV:
    - On each fall, shift synchronised data into a 10-bit register from the MSB end, decrement the counter, and clear the timer.
    - The fall that arrives when the counter is 1 (the stop bit) -> CHECK.
    - Timer reaches TIMEOUT_CYCLES -> frame_err_o pulse, go to IDLE.
    - rx_en_i=0 -> IDLE, no pulses.
  - CHECK (one cycle), evaluated in this priority order:
    1. Stop bit 0 -> frame_err_o=1.
    2. Else, parity check enabled and XOR(D7..D0, parity) != 1 -> parity_err_o=1.
    3. Else rx_data_o<=D, rx_done_o=1.
    - Always -> IDLE next cycle.
- Latency: rx_done_o is high exactly one cycle after the stop-bit fall cycle.
- Error pulses are mutually exclusive with rx_done_o.
- rx_data_o is untouched on error or abort.
- Timer saturates and never wraps.
- Edge cases:
  - A glitch shorter than FILTER_LEN cycles never produces a fall.
  - A simultaneous fall and timeout in RECV: the fall wins.

Optional Feature:
- Macro PS2_RX_PARITY_CHECK_EN.
- Defined: parity is checked as above; a bad frame pulses parity_err_o and suppresses rx_done_o.
- Undefined: the parity bit is shifted but ignored; parity_err_o is tied to 0; frames with a good stop bit always produce rx_done_o.

Decomposition:
- Shared ps2_pkg (also used by ps2_tx):
  - state enum typedef ps2_rx_state_t {IDLE, RECV, CHECK}.
  - PS2_FRAME_BITS=11, PS2_DATA_BITS=8.
  - command/response constants: ACK 0xFA, ENABLE 0xF4, RESET 0xFF.
- One sub-module, ps2_line_filter:
  - 2-FF synchroniser, FILTER_LEN level filter, falling-edge pulse.
  - Parameterised by FILTER_LEN.
  - Instantiated for ps2c; reusable by ps2_tx.

Test Plan:
Bench drives ps2c at 40 us period (4000 cycles), changes data mid-high, rx_en_i=1 unless stated.
- Frame 0xFA, parity 1, stop 1 -> single rx_done_o pulse one cycle after the final fall; rx_data_o=0xFA; no error pulses; idle_o back to 1.
- Frame 0xAA with parity 0 (bad) -> macro defined: parity_err_o pulse, no rx_done_o, rx_data_o still 0xFA. Undefined: rx_done_o with 0xAA.
- Frame 0x55, parity 1, stop 0 -> frame_err_o pulse, no rx_done_o; next frame 0x1C received correctly.
- 3-cycle low glitch on ps2c in IDLE, and a 5-cycle glitch mid-frame -> no extra bits, idle_o unaffected; surrounding frame 0x29 received intact.
- Clocking stops after D3 -> frame_err_o pulses after TIMEOUT_CYCLES cycles with no falls, idle_o=1; following 0xF4 frame received.
- Two cases, each followed by frame 0x12 received correctly:
  - reset_ni=0 for 2 cycles mid-frame (after D5) -> all outputs at reset values immediately.
  - rx_en_i dropped mid-frame -> no pulses.
